is_uart_tx_arb: RTL and testbench
=================================

Name: is_uart_tx_arb

Overview:
- Shares the single UART transmitter handshake (tx_rdy_t / tx_data / tx_rdy_r of is_uart_controller) between N_REQ byte-stream requesters, e.g. the main FSM echo path and a status/diagnostic message source.
- Grants are message-granular: a requester holds the transmitter until its byte flagged last is accepted, or until an idle timeout releases it.
- Round-robin fairness between requesters.
- Sits between the requesters and is_uart_controller in is_uart_top.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- DATA_W, 8 (from is_pkg_uart_controller), byte width.
- TIMEOUT_CYC, 1_000_000, cycles a granted requester may hold valid low mid-message before forced release (10 ms at 100 MHz).

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rstn_i  in  1  reset: asynchronous, active-low. Driven from the synchronized reset.
- req_valid_i  in  N_REQ  per-requester byte valid.
- req_data_i  in  N_REQ*DATA_W  packed bytes. Requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  N_REQ  marks the final byte of a message. Qualified by valid.
- req_ready_o  out  N_REQ  byte accepted from requester k when valid[k] & ready[k].
- grant_o  out  N_REQ  one-hot current owner. All-zero when idle.
- busy_o  out  1  high while a grant is held.
- timeout_o  out  1  one-cycle pulse on forced release.
- tx_rdy_t_o  out  1  byte valid to the UART controller.
- tx_data_t_o  out  DATA_W  byte to the UART controller.
- tx_rdy_r_i  in  1  controller ready. A byte transfers on tx_rdy_t_o & tx_rdy_r_i in the same cycle.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, rr_ptr=0, timeout counter=0.
  - All outputs 0.
- States: IDLE, LOCK.
- IDLE:
  - tx_rdy_t_o=0, req_ready_o=0.
  - If any req_valid_i: pick the first valid requester searching from rr_ptr upward with wrap (rr_ptr itself first).
  - Register grant one-hot and go to LOCK.
  - Grant latency: 1 cycle from valid to grant_o. First byte is eligible to transfer in the cycle grant_o rises.
- LOCK, owner g, combinational pass-through:
  - tx_rdy_t_o = req_valid_i[g].
  - tx_data_t_o = req_data_i[g].
  - req_ready_o[g] = tx_rdy_r_i. Other ready bits 0.
  - tx_data_t_o = 0 when not in LOCK.
- Message end: a transfer with req_last_i[g]=1 moves to IDLE next cycle, clears grant, and sets rr_ptr = (g+1) mod N_REQ.
  - Re-arbitration happens in IDLE, so there is one idle cycle between messages.
- Timeout counter:
  - Increments each LOCK cycle with req_valid_i[g]=0.
  - Clears on any LOCK cycle with valid high, and in IDLE.
  - Reaching TIMEOUT_CYC-1 with valid still low: next cycle go to IDLE, pulse timeout_o, rr_ptr = (g+1) mod N_REQ.
  - Counter width is $clog2(TIMEOUT_CYC).
  - Valid high while controller not ready (back-pressure) never counts toward timeout.
- Simultaneous events:
  - If the last-byte transfer and timeout expiry coincide, the last byte wins: no timeout pulse.
  - Requests from non-owners during LOCK are ignored and must be held by the requester.
- Data/last stability: a requester must hold data/last stable while valid & !ready. The arbiter does not register data.
- Reset mid-message: grant drops immediately (async). A partially sent message is not resumed.
- Invariants (assert in bench):
  - grant_o is one-hot or zero.
  - At most one req_ready_o bit is high.
  - tx_rdy_t_o implies busy_o.

Decomposition:
- Add to is_pkg_uart_controller:
  - typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t.
  - localparam ARB_TIMEOUT_CYC.
- Sub-module is_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, rr_ptr. Outputs: one-hot pick, any-valid flag.
  - Reusable by later arbiters.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) with tx_rdy_r_i always 1.
  -> grant_o=01 one cycle after valid. Bytes appear on tx_data_t_o on 3 consecutive cycles. busy_o drops the cycle after 0x43. rr_ptr=1.
- Contention: req0 and req1 both assert valid in the same cycle from reset.
  -> req0 granted first. Its 2-byte message completes, 1 idle cycle, then req1 is granted. No interleaving of bytes.
- Fairness: both requesters continuously send 1-byte messages (last=1 every byte).
  -> grants alternate 01, 10, 01, 10. Exactly one idle cycle between grants.
- Back-pressure: tx_rdy_r_i low for 50 cycles mid-message with req1 valid high and TIMEOUT_CYC=16.
  -> no timeout_o. The byte is held on tx_data_t_o and transfers when ready returns.
- Timeout: TIMEOUT_CYC=16; req0 sends a non-last byte, then drops valid.
  -> timeout_o pulses exactly 16 cycles after valid dropped, grant clears, and a pending req1 is granted next cycle.
- Reset mid-message: assert rstn_i=0 asynchronously between clock edges while req1 is granted.
  -> grant_o, busy_o, tx_rdy_t_o and req_ready_o go to 0 without a clock edge. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/is_pkg_uart_controller.sv
// Shared types and constants for the UART controller and its transmit-side arbiter.
package is_pkg_uart_controller;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned ARB_TIMEOUT_CYC = 1_000_000;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/is_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, with wrap.
module is_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     pick_o,
    output logic             any_o
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        pick_o  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = PTR_W'((32'(rr_ptr_i) + i) % N);
            if (!w_found && req_i[w_idx]) begin
                pick_o[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/is_uart_tx_arb.sv
// Message-granular round-robin arbiter sharing one UART transmit handshake between N_REQ byte streams.
module is_uart_tx_arb
    import is_pkg_uart_controller::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned DATA_W      = is_pkg_uart_controller::DATA_W,
    parameter int unsigned TIMEOUT_CYC = is_pkg_uart_controller::ARB_TIMEOUT_CYC
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    input  logic [N_REQ-1:0]         req_last_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic                     tx_rdy_t_o,
    output logic [DATA_W-1:0]        tx_data_t_o,
    input  logic                     tx_rdy_r_i
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t         r_state,   w_state_nxt;
    logic [N_REQ-1:0]   r_grant,   w_grant_nxt;
    logic [PTR_W-1:0]   r_rr_ptr,  w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_to_cnt,  w_to_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [N_REQ-1:0]   w_pick;
    logic               w_any;
    logic [PTR_W-1:0]   w_owner;
    logic [PTR_W-1:0]   w_ptr_after;
    logic [DATA_W-1:0]  w_data_g;
    logic               w_valid_g;
    logic               w_last_g;
    logic               w_lock;
    logic               w_xfer;

    is_rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i    (req_valid_i),
        .rr_ptr_i (r_rr_ptr),
        .pick_o   (w_pick),
        .any_o    (w_any)
    );

    // Owner index and byte select from the one-hot grant.
    always_comb begin
        w_owner  = '0;
        w_data_g = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_owner  = PTR_W'(k);
                w_data_g = w_data_g | req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_valid_g   = |(req_valid_i & r_grant);
    assign w_last_g    = |(req_last_i & r_grant);
    assign w_lock      = (r_state == ARB_LOCK);
    assign w_xfer      = w_lock & w_valid_g & tx_rdy_r_i;
    assign w_ptr_after = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + PTR_W'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Last-byte release takes priority; the idle counter only runs while the owner holds valid low.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_to_cnt_nxt  = '0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (w_xfer && w_last_g) begin
                    w_state_nxt  = ARB_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_ptr_after;
                end else if (!w_valid_g) begin
                    if (r_to_cnt == CNT_MAX) begin
                        w_state_nxt   = ARB_IDLE;
                        w_grant_nxt   = '0;
                        w_rr_ptr_nxt  = w_ptr_after;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant_o     = r_grant;
    assign busy_o      = w_lock;
    assign timeout_o   = r_timeout;
    assign tx_rdy_t_o  = w_lock & w_valid_g;
    assign tx_data_t_o = w_lock ? w_data_g : '0;
    assign req_ready_o = w_lock ? (r_grant & {N_REQ{tx_rdy_r_i}}) : '0;

endmodule

// File: tb/tb_is_uart_tx_arb.sv
// Bench for is_uart_tx_arb: directed scenarios plus randomized traffic against an ownership-level reference model.
module tb_is_uart_tx_arb;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         gap;
    } item_t;

    typedef struct {
        int           cyc;
        logic [7:0]   d;
        logic [N-1:0] g;
    } rec_t;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [N-1:0]    req_valid_i;
    logic [N*DW-1:0] req_data_i;
    logic [N-1:0]    req_last_i;
    logic [N-1:0]    req_ready_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic            timeout_o;
    logic            tx_rdy_t_o;
    logic [DW-1:0]   tx_data_t_o;
    logic            tx_rdy_r_i;

    always #5 clk = ~clk;

    is_uart_tx_arb #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .tx_rdy_t_o  (tx_rdy_t_o),
        .tx_data_t_o (tx_data_t_o),
        .tx_rdy_r_i  (tx_rdy_r_i)
    );

    item_t q [N][$];
    rec_t  log_q [$];
    int    to_q [$];
    int    cyc    = 0;
    int    n_vec  = 0;
    int    n_err  = 0;

    // Reference model: who owns the transmitter, whose turn is next, how long the owner has been silent.
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_quiet = 0;
    logic        m_tp    = 1'b0;
    logic [N-1:0] m_acc  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_quiet = 0;
        m_tp    = 1'b0;
        m_acc   = '0;
    endtask

    function automatic rec_t lg(input int i);
        rec_t r;
        r = '{-1, 8'h00, '0};
        if (i < log_q.size()) r = log_q[i];
        return r;
    endfunction

    task automatic cycle();
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        logic          et;
        int            o;
        @(negedge clk);
        eg = '0; er = '0; ed = '0; et = 1'b0; o = m_owner;
        if (o >= 0) begin
            eg[o] = 1'b1;
            et    = req_valid_i[o];
            ed    = req_data_i[o*DW +: DW];
            er[o] = tx_rdy_r_i;
        end
        check("grant_o",     32'(grant_o),     32'(eg));
        check("busy_o",      32'(busy_o),      32'(o >= 0));
        check("timeout_o",   32'(timeout_o),   32'(m_tp));
        check("tx_rdy_t_o",  32'(tx_rdy_t_o),  32'(et));
        check("tx_data_t_o", 32'(tx_data_t_o), 32'(ed));
        check("req_ready_o", 32'(req_ready_o), 32'(er));
        check("inv_grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
        check("inv_ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
        check("inv_tx_implies_busy", 32'(!tx_rdy_t_o || busy_o), 32'd1);
        if (tx_rdy_t_o && tx_rdy_r_i) log_q.push_back('{cyc, tx_data_t_o, grant_o});
        if (timeout_o) to_q.push_back(cyc);
        m_acc = er & req_valid_i;
        if (!rstn_i) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_tp    = 1'b0;
            m_quiet = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_owner < 0 && req_valid_i[k]) m_owner = k;
            end
        end else begin
            m_tp = 1'b0;
            if (req_valid_i[o] && tx_rdy_r_i && req_last_i[o]) begin
                m_owner = -1; m_ptr = (o + 1) % N; m_quiet = 0;
            end else if (req_valid_i[o]) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_owner = -1; m_ptr = (o + 1) % N; m_quiet = 0; m_tp = 1'b1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l, input int gap);
        item_t it;
        it.d = d; it.l = l; it.gap = gap;
        q[k].push_back(it);
    endtask

    // Requester behaviour: present the head byte after its gap, hold it until accepted.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (!req_valid_i[k] && q[k].size() > 0) begin
                item_t it;
                it = q[k][0];
                if (it.gap > 0) begin
                    it.gap--;
                    q[k][0] = it;
                end else begin
                    req_valid_i[k]         = 1'b1;
                    req_data_i[k*DW +: DW] = it.d;
                    req_last_i[k]          = it.l;
                end
            end
        end
    endtask

    task automatic post();
        for (int k = 0; k < N; k++) begin
            if (m_acc[k]) begin
                void'(q[k].pop_front());
                req_valid_i[k]         = 1'b0;
                req_last_i[k]          = 1'b0;
                req_data_i[k*DW +: DW] = '0;
            end
        end
    endtask

    function automatic bit drained();
        bit e;
        e = (req_valid_i == '0);
        for (int k = 0; k < N; k++) if (q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic step(input bit rnd_rdy);
        drive();
        if (rnd_rdy) tx_rdy_r_i = ($urandom_range(0, 3) != 0);
        cycle();
        post();
    endtask

    task automatic run_drain(input int max, input bit rnd_rdy);
        for (int t = 0; t < max && !drained(); t++) step(rnd_rdy);
        check("drain_bound", 32'(drained()), 32'd1);
        tx_rdy_r_i = 1'b1;
        cycle();
    endtask

    task automatic reset_all();
        rstn_i      = 1'b0;
        model_reset();
        for (int k = 0; k < N; k++) q[k].delete();
        log_q.delete();
        to_q.delete();
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        tx_rdy_r_i  = 1'b0;
        cycle();
        cycle();
        rstn_i     = 1'b1;
        tx_rdy_r_i = 1'b1;
    endtask

    initial begin
        int c0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        tx_rdy_r_i  = 1'b0;
        rstn_i      = 1'b0;

        // Single requester, three-byte message.
        reset_all();
        check("reset_grant", 32'(grant_o), 32'd0);
        check("reset_busy",  32'(busy_o),  32'd0);
        c0 = cyc;
        push(0, 8'h41, 1'b0, 0);
        push(0, 8'h42, 1'b0, 0);
        push(0, 8'h43, 1'b1, 0);
        for (int t = 0; t < 20 && !drained(); t++) step(1'b0);
        check("single_busy_drop", 32'(busy_o), 32'd0);
        check("single_cnt", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("single_data",  32'(lg(i).d),   32'(8'h41 + i));
            check("single_cyc",   32'(lg(i).cyc), 32'(c0 + 1 + i));
            check("single_grant", 32'(lg(i).g),   32'd1);
        end
        // Pointer advanced to requester 1.
        log_q.delete();
        push(0, 8'h55, 1'b1, 0);
        push(1, 8'h66, 1'b1, 0);
        run_drain(20, 1'b0);
        check("rrptr_first",  32'(lg(0).g), 32'd2);
        check("rrptr_second", 32'(lg(1).g), 32'd1);

        // Contention from reset: requester 0 wins, whole messages, one idle cycle between.
        reset_all();
        push(0, 8'hA0, 1'b0, 0); push(0, 8'hA1, 1'b1, 0);
        push(1, 8'hB0, 1'b0, 0); push(1, 8'hB1, 1'b1, 0);
        run_drain(30, 1'b0);
        check("cont_d0", 32'(lg(0).d), 32'hA0);
        check("cont_d1", 32'(lg(1).d), 32'hA1);
        check("cont_d2", 32'(lg(2).d), 32'hB0);
        check("cont_d3", 32'(lg(3).d), 32'hB1);
        check("cont_gap",  32'(lg(2).cyc - lg(1).cyc), 32'd2);
        check("cont_b_b2b", 32'(lg(3).cyc - lg(2).cyc), 32'd1);

        // Fairness with single-byte messages.
        reset_all();
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(8'h60 + i), 1'b1, 0);
            push(1, 8'(8'h70 + i), 1'b1, 0);
        end
        run_drain(60, 1'b0);
        for (int j = 0; j < 8; j++) begin
            check("fair_grant", 32'(lg(j).g), (j % 2 == 0) ? 32'd1 : 32'd2);
            if (j > 0) check("fair_spacing", 32'(lg(j).cyc - lg(j-1).cyc), 32'd2);
        end

        // Back-pressure longer than the timeout must not release the owner.
        reset_all();
        push(1, 8'h81, 1'b0, 0); push(1, 8'h82, 1'b0, 0); push(1, 8'h83, 1'b1, 0);
        for (int i = 0; i < 70; i++) begin
            drive();
            tx_rdy_r_i = !(i >= 3 && i < 53);
            cycle();
            post();
        end
        tx_rdy_r_i = 1'b1;
        check("bp_no_timeout", 32'(to_q.size()), 32'd0);
        check("bp_cnt",  32'(log_q.size()), 32'd3);
        check("bp_data", 32'(lg(2).d), 32'h83);
        check("bp_hold", 32'(lg(2).cyc - lg(1).cyc), 32'd51);

        // Owner goes silent mid-message: forced release, pending requester granted next cycle.
        reset_all();
        push(0, 8'h10, 1'b0, 0); push(0, 8'h11, 1'b1, 40);
        push(1, 8'h20, 1'b1, 3);
        run_drain(120, 1'b0);
        check("to_pulses",  32'(to_q.size()), 32'd1);
        check("to_latency", 32'(to_q[0] - (lg(0).cyc + 1)), 32'd16);
        check("to_next_cyc",   32'(lg(1).cyc), 32'(to_q[0] + 1));
        check("to_next_grant", 32'(lg(1).g), 32'd2);
        check("to_next_data",  32'(lg(1).d), 32'h20);
        check("to_resume_data", 32'(lg(2).d), 32'h11);

        // Asynchronous reset while requester 1 is mid-message.
        reset_all();
        push(0, 8'h01, 1'b1, 0);
        run_drain(10, 1'b0);
        for (int i = 0; i < 5; i++) push(1, 8'(8'hC0 + i), 1'(i == 4), 0);
        for (int i = 0; i < 3; i++) step(1'b0);
        check("ar_pre_grant", 32'(grant_o), 32'd2);
        #2;
        rstn_i = 1'b0;
        #1;
        check("ar_grant", 32'(grant_o),     32'd0);
        check("ar_busy",  32'(busy_o),      32'd0);
        check("ar_txrdy", 32'(tx_rdy_t_o),  32'd0);
        check("ar_ready", 32'(req_ready_o), 32'd0);
        model_reset();
        for (int k = 0; k < N; k++) q[k].delete();
        req_valid_i = '0; req_last_i = '0; req_data_i = '0;
        cycle();
        rstn_i = 1'b1;
        log_q.delete();
        push(0, 8'hD0, 1'b1, 0);
        push(1, 8'hD1, 1'b1, 0);
        run_drain(20, 1'b0);
        check("ar_restart_first", 32'(lg(0).g), 32'd1);
        check("ar_restart_data",  32'(lg(0).d), 32'hD0);

        // Randomized traffic, random back-pressure, occasional long silences.
        reset_all();
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < 10; m++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    int gap;
                    gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 24))
                                                      : int'($urandom_range(0, 2));
                    push(k, 8'($urandom), 1'(b == len - 1), gap);
                end
            end
        end
        run_drain(4000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
